// File: rtl/sm_mem_arbiter.sv
// Shares one fixed-latency memory between fetch (I) and data (D) ports; SM_ARB_ROUND_ROBIN_EN selects alternating arbitration (default: D over I).
// Read data returns MEM_LAT cycles after grant; no grants while a read is outstanding, except in its completion cycle.
module sm_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_gnt_o,
    output logic              i_rvalid_o,
    output logic [DATA_W-1:0] i_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              m_req_o,
    output logic              m_we_o,
    output logic [ADDR_W-1:0] m_addr_o,
    output logic [DATA_W-1:0] m_wdata_o,
    input  logic [DATA_W-1:0] m_rdata_i,
    output logic              busy_o
);

    if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_lat
        $error("sm_mem_arbiter: MEM_LAT must be in 1..7");
    end

    typedef enum logic {ST_IDLE, ST_WAIT} state_e;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;

    logic rd_done;
    logic grant_ok;
    logic pick_d;
    logic i_gnt, d_gnt, i_rvalid, d_rvalid;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            owner_q <= PORT_I;
            last_q  <= PORT_D;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        last_d   = last_q;
        pick_d   = 1'b0;
        i_gnt    = 1'b0;
        d_gnt    = 1'b0;
        i_rvalid = 1'b0;
        d_rvalid = 1'b0;

        rd_done  = (state_q == ST_WAIT) && (cnt_q == 3'd1);
        // The completion cycle of a read doubles as an issue slot.
        grant_ok = rst_n_i && ((state_q == ST_IDLE) || rd_done);

        if (state_q == ST_WAIT) begin
            cnt_d = cnt_q - 3'd1;
            if (rd_done) begin
                state_d  = ST_IDLE;
                d_rvalid = rst_n_i && (owner_q == PORT_D);
                i_rvalid = rst_n_i && (owner_q == PORT_I);
            end
        end

        if (grant_ok) begin
            if (d_req_i && i_req_i) begin
`ifdef SM_ARB_ROUND_ROBIN_EN
                pick_d = (last_q == PORT_I);
`else
                pick_d = 1'b1;
`endif
            end else begin
                pick_d = d_req_i;
            end
            d_gnt = pick_d;
            i_gnt = i_req_i && !pick_d;
        end

        if (i_gnt || d_gnt) begin
            last_d = d_gnt;
            // Writes finish in the grant cycle; only reads occupy the memory.
            if (i_gnt || !d_we_i) begin
                state_d = ST_WAIT;
                cnt_d   = 3'(MEM_LAT);
                owner_d = d_gnt;
            end
        end
    end

    assign i_gnt_o    = i_gnt;
    assign d_gnt_o    = d_gnt;
    assign i_rvalid_o = i_rvalid;
    assign d_rvalid_o = d_rvalid;
    assign i_rdata_o  = i_rvalid ? m_rdata_i : '0;
    assign d_rdata_o  = d_rvalid ? m_rdata_i : '0;
    assign m_req_o    = i_gnt | d_gnt;
    assign m_we_o     = d_gnt & d_we_i;
    assign m_addr_o   = d_gnt ? d_addr_i : (i_gnt ? i_addr_i : '0);
    assign m_wdata_o  = d_gnt ? d_wdata_i : '0;
    assign busy_o     = rst_n_i && (state_q == ST_WAIT);

endmodule

// File: tb/tb_sm_mem_arbiter.sv
// Bench for sm_mem_arbiter with MEM_LAT=2: directed scenarios plus a random I/D mix,
// checked every cycle against a transaction-level model and a few literal expectations.
module tb_sm_mem_arbiter;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, m_we, busy;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;

    int total = 0;
    int bad   = 0;

    sm_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .i_req_i(i_req), .i_addr_i(i_addr), .i_gnt_o(i_gnt),
        .i_rvalid_o(i_rvalid), .i_rdata_o(i_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
        .m_req_o(m_req), .m_we_o(m_we), .m_addr_o(m_addr), .m_wdata_o(m_wdata),
        .m_rdata_i(m_rdata), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [7:0] a);
        return 32'h1000_0000 + {24'd0, a};
    endfunction

    // Memory environment: fixed-latency read pipe, writes land at the grant edge.
    logic [31:0] mem  [256];
    bit   [255:0] memw;
    logic [31:0] rpipe [LAT];
    always @(posedge clk) begin
        if (m_req && m_we) begin
            mem[m_addr[7:0]]  <= m_wdata;
            memw[m_addr[7:0]] <= 1'b1;
        end
        rpipe[0] <= (m_req && !m_we) ? (memw[m_addr[7:0]] ? mem[m_addr[7:0]] : init_val(m_addr[7:0]))
                                     : 32'h0BAD_0BAD;
        for (int k = 1; k < LAT; k++) rpipe[k] <= rpipe[k-1];
    end
    assign m_rdata = rpipe[LAT-1];

    // Transaction-level model: memory is free unless a read is pending; a pending read
    // completes LAT cycles after its grant and that completion cycle may issue again.
    logic [31:0] refm [256];
    bit   [255:0] refw;
    int          cyc = 0;
    bit          pend = 0;
    int          due = 0;
    bit          pend_port = 0;
    logic [31:0] pend_data = 0;
    bit          last_port = 1'b1;

    int          g_cyc[$];
    bit          g_port[$];
    bit          g_we[$];
    logic [31:0] g_addr[$];
    int          r_cyc[$];
    bit          r_port[$];
    logic [31:0] r_data[$];

    task automatic clear_logs();
        g_cyc.delete(); g_port.delete(); g_we.delete(); g_addr.delete();
        r_cyc.delete(); r_port.delete(); r_data.delete();
    endtask

    always @(negedge clk) begin
        bit rv, free, win_i, win_d;
        logic [31:0] e_addr, e_wdata;
        cyc++;
        if (!rst_n) begin
            chk("rst_ctrl", {25'd0, i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, m_we, busy}, 32'd0);
            chk("rst_i_rdata", i_rdata, 32'd0);
            chk("rst_d_rdata", d_rdata, 32'd0);
            chk("rst_m_addr", m_addr, 32'd0);
            chk("rst_m_wdata", m_wdata, 32'd0);
            pend      = 1'b0;
            last_port = 1'b1;
        end else begin
            rv    = pend && (due == cyc);
            free  = !pend || rv;
            win_i = 1'b0;
            win_d = 1'b0;
            if (free) begin
                if (i_req && d_req) begin
`ifdef SM_ARB_ROUND_ROBIN_EN
                    win_d = (last_port == 1'b0);
`else
                    win_d = 1'b1;
`endif
                    win_i = !win_d;
                end else begin
                    win_d = d_req;
                    win_i = i_req;
                end
            end
            e_addr  = win_d ? d_addr : (win_i ? i_addr : 32'd0);
            e_wdata = win_d ? d_wdata : 32'd0;
            chk("i_gnt", {31'd0, i_gnt}, {31'd0, win_i});
            chk("d_gnt", {31'd0, d_gnt}, {31'd0, win_d});
            chk("m_req", {31'd0, m_req}, {31'd0, win_i | win_d});
            chk("m_we", {31'd0, m_we}, {31'd0, win_d & d_we});
            chk("m_addr", m_addr, e_addr);
            chk("m_wdata", m_wdata, e_wdata);
            chk("busy", {31'd0, busy}, {31'd0, pend});
            chk("i_rvalid", {31'd0, i_rvalid}, {31'd0, rv && !pend_port});
            chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, rv && pend_port});
            chk("i_rdata", i_rdata, (rv && !pend_port) ? pend_data : 32'd0);
            chk("d_rdata", d_rdata, (rv && pend_port) ? pend_data : 32'd0);

            if (i_gnt || d_gnt) begin
                g_cyc.push_back(cyc); g_port.push_back(d_gnt);
                g_we.push_back(m_we); g_addr.push_back(m_addr);
            end
            if (i_rvalid || d_rvalid) begin
                r_cyc.push_back(cyc); r_port.push_back(d_rvalid);
                r_data.push_back(d_rvalid ? d_rdata : i_rdata);
            end

            if (rv) pend = 1'b0;
            if (win_i || win_d) begin
                last_port = win_d;
                if (win_d && d_we) begin
                    refm[e_addr[7:0]] = d_wdata;
                    refw[e_addr[7:0]] = 1'b1;
                end else begin
                    pend      = 1'b1;
                    due       = cyc + LAT;
                    pend_port = win_d;
                    pend_data = refw[e_addr[7:0]] ? refm[e_addr[7:0]] : init_val(e_addr[7:0]);
                end
            end
        end
    end

    // Requesters: hold a request until granted, then present the next one.
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;
    req_t iq[$];
    req_t dq[$];
    bit   i_act = 0;
    bit   d_act = 0;

    task automatic wait_gnt(input bit port_d);
        int n = 0;
        @(negedge clk);
        while (!(port_d ? d_gnt : i_gnt) && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (!(port_d ? d_gnt : i_gnt)) begin
            total++; bad++;
            $display("FAIL gnt_timeout port_d=%0d: got no grant within %0d cycles, expected one", port_d, n);
        end
    endtask

    initial begin
        req_t r;
        i_req = 1'b0; i_addr = 32'd0;
        @(posedge clk); #1;
        forever begin
            if (iq.size() != 0) begin
                r = iq.pop_front();
                i_act = 1'b1; i_req = 1'b1; i_addr = r.addr;
                wait_gnt(1'b0);
                @(posedge clk); #1;
            end else begin
                i_act = 1'b0; i_req = 1'b0; i_addr = 32'd0;
                @(posedge clk); #1;
            end
        end
    end

    initial begin
        req_t r;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
        @(posedge clk); #1;
        forever begin
            if (dq.size() != 0) begin
                r = dq.pop_front();
                d_act = 1'b1; d_req = 1'b1; d_we = r.we; d_addr = r.addr; d_wdata = r.wdata;
                wait_gnt(1'b1);
                @(posedge clk); #1;
            end else begin
                d_act = 1'b0; d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
                @(posedge clk); #1;
            end
        end
    end

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while ((iq.size() != 0 || dq.size() != 0 || i_act || d_act || busy) && n < 3000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 3000) begin
            total++; bad++;
            $display("FAIL drain_timeout: got still active after %0d cycles, expected idle", n);
        end
        repeat (3) @(negedge clk);
        #2;
    endtask

    task automatic reset_pulse(input int n);
        @(negedge clk); #2;
        rst_n = 1'b0;
        repeat (n) @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] seq;
        int nreads;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;

        // Lone fetch read.
        clear_logs();
        iq.push_back('{we: 1'b0, addr: 32'h10, wdata: 32'h0});
        drain();
        chk("t1_ngnt", g_cyc.size(), 32'd1);
        chk("t1_port", {31'd0, g_port[0]}, 32'd0);
        chk("t1_maddr", g_addr[0], 32'h10);
        chk("t1_lat", r_cyc[0] - g_cyc[0], 32'd2);
        chk("t1_rdata", r_data[0], 32'h1000_0010);
        chk("t1_rport", {31'd0, r_port[0]}, 32'd0);

        // Write then read back.
        clear_logs();
        dq.push_back('{we: 1'b1, addr: 32'h20, wdata: 32'hDEAD_BEEF});
        dq.push_back('{we: 1'b0, addr: 32'h20, wdata: 32'h0});
        drain();
        chk("t2_ngnt", g_cyc.size(), 32'd2);
        chk("t2_we", {31'd0, g_we[0]}, 32'd1);
        chk("t2_nrv", r_cyc.size(), 32'd1);
        chk("t2_rdata", r_data[0], 32'hDEAD_BEEF);
        chk("t2_rport", {31'd0, r_port[0]}, 32'd1);
        chk("t2_back2back", g_cyc[1] - g_cyc[0], 32'd1);

        // Contention: four reads on each port presented together after reset (last = D).
        reset_pulse(1);
        clear_logs();
        @(negedge clk); #2;
        for (int k = 0; k < 4; k++) begin
            iq.push_back('{we: 1'b0, addr: 32'h40 + k, wdata: 32'h0});
            dq.push_back('{we: 1'b0, addr: 32'h50 + k, wdata: 32'h0});
        end
        drain();
`ifdef SM_ARB_ROUND_ROBIN_EN
        seq = 8'b1010_1010;
`else
        seq = 8'b0000_1111;
`endif
        chk("t3_ngnt", g_cyc.size(), 32'd8);
        for (int k = 0; k < 8; k++) chk($sformatf("t3_order%0d", k), {31'd0, g_port[k]}, {31'd0, seq[k]});

        // Read spacing and overlapped issue.
        clear_logs();
        for (int k = 0; k < 3; k++) iq.push_back('{we: 1'b0, addr: 32'h60 + k, wdata: 32'h0});
        drain();
        chk("t4_space0", g_cyc[1] - g_cyc[0], 32'd2);
        chk("t4_space1", g_cyc[2] - g_cyc[1], 32'd2);
        clear_logs();
        iq.push_back('{we: 1'b0, addr: 32'h70, wdata: 32'h0});
        @(negedge clk); #2;
        dq.push_back('{we: 1'b0, addr: 32'h71, wdata: 32'h0});
        drain();
        chk("t4_ports", {30'd0, g_port[0], g_port[1]}, 32'd1);
        chk("t4_dwait", g_cyc[1] - g_cyc[0], 32'd2);
        chk("t4_overlap", r_cyc[0], g_cyc[1]);
        chk("t4_ddata", r_data[1], 32'h1000_0071);

        // Reset while a read is outstanding.
        clear_logs();
        iq.push_back('{we: 1'b0, addr: 32'h05, wdata: 32'h0});
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("t5_ngnt", g_cyc.size(), 32'd1);
        chk("t5_norv", r_cyc.size(), 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        #2;
        clear_logs();
        dq.push_back('{we: 1'b0, addr: 32'h07, wdata: 32'h0});
        drain();
        chk("t5_nrv", r_cyc.size(), 32'd1);
        chk("t5_rdata", r_data[0], 32'h1000_0007);

        // Random mix, checked cycle by cycle.
        clear_logs();
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk); #2;
            if (iq.size() == 0 && $urandom_range(0, 2) == 0)
                iq.push_back('{we: 1'b0, addr: 32'($urandom_range(0, 31)), wdata: 32'h0});
            if (dq.size() == 0 && $urandom_range(0, 3) == 0)
                dq.push_back('{we: 1'($urandom_range(0, 1)), addr: 32'($urandom_range(0, 31)),
                               wdata: $urandom});
        end
        drain();
        nreads = 0;
        foreach (g_we[k]) if (!g_we[k]) nreads++;
        chk("t6_rv_per_read", r_cyc.size(), nreads);
        chk("t6_activity", {31'd0, nreads > 100}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
